cdb_issue_scheduler: RTL and testbench



---
 rtl/issue_pkg.sv | 24 ++
 rtl/cdb_issue_scheduler_slot_tracker.sv | 45 ++++
 rtl/cdb_issue_scheduler.sv | 113 +++++++++++
 tb/tb_cdb_issue_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and default latencies for the CDB issue scheduler slice.
package issue_pkg;

    localparam int unsigned NUM_FU      = 4;
    localparam int unsigned DEF_LAT_INT = 1;
    localparam int unsigned DEF_LAT_MEM = 3;
    localparam int unsigned DEF_LAT_MUL = 4;
    localparam int unsigned DEF_LAT_DIV = 6;
    localparam int unsigned DEF_MAX_LAT = 6;

    typedef logic [1:0] fu_idx_t;

    typedef enum logic [1:0] {
        FU_INT = 2'd0,
        FU_MEM = 2'd1,
        FU_MUL = 2'd2,
        FU_DIV = 2'd3
    } fu_e;

    function automatic logic [NUM_FU-1:0] fu_onehot(input fu_idx_t idx);
        return (NUM_FU)'(1) << idx;
    endfunction

endpackage

// File: rtl/cdb_issue_scheduler_slot_tracker.sv
// CDB reservation shift register: slot k is the bus k cycles from now, slot 0 drives the CDB.
module cdb_slot_tracker #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned IDXW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_res_vld,
    input  logic [IDXW-1:0] i_res_idx,
    input  logic [1:0]      i_res_own,
    output logic [DEPTH-1:0] o_occ,
    output logic            o_cdb_valid,
    output logic [1:0]      o_cdb_src
);

    logic [DEPTH-1:0]      r_occ;
    logic [DEPTH-1:0][1:0] r_own;
    logic [DEPTH-1:0]      w_occ_nxt;
    logic [DEPTH-1:0][1:0] w_own_nxt;

    // Shift toward slot 0 first, then land the new reservation on the post-shift index.
    always_comb begin
        w_occ_nxt = r_occ >> 1;
        w_own_nxt = r_own >> 2;
        if (i_res_vld) begin
            w_occ_nxt[i_res_idx] = 1'b1;
            w_own_nxt[i_res_idx] = i_res_own;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
            r_own <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            r_own <= w_own_nxt;
        end
    end

    assign o_occ       = r_occ;
    assign o_cdb_valid = r_occ[0];
    assign o_cdb_src   = r_occ[0] ? r_own[0] : 2'b00;

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Single-issue round-robin scheduler for INT/MEM/MUL/DIV that reserves the CDB at issue time
// and holds off the non-pipelined divider while it is busy.
module cdb_issue_scheduler
    import issue_pkg::*;
#(
    parameter int unsigned LAT_INT = DEF_LAT_INT,
    parameter int unsigned LAT_MEM = DEF_LAT_MEM,
    parameter int unsigned LAT_MUL = DEF_LAT_MUL,
    parameter int unsigned LAT_DIV = DEF_LAT_DIV,
    parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       cdb_valid,
    output logic [1:0] cdb_src,
    output logic       div_busy
);

    localparam int unsigned IDXW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned CNTW = $clog2(MAX_LAT) + 1;
    localparam int unsigned LAT_A = (LAT_INT > LAT_MEM) ? LAT_INT : LAT_MEM;
    localparam int unsigned LAT_B = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
    localparam int unsigned LAT_TOP = (LAT_A > LAT_B) ? LAT_A : LAT_B;

    if (MAX_LAT != LAT_TOP
        || LAT_INT < 1 || LAT_MEM < 1 || LAT_MUL < 1 || LAT_DIV < 1) begin : g_bad_latency
        $error("cdb_issue_scheduler: MAX_LAT must equal the largest LAT_* and every LAT_* must be 1..MAX_LAT");
    end

    logic [MAX_LAT-1:0] w_occ;
    logic [MAX_LAT:0]   w_occ_ext;
    logic [NUM_FU-1:0]  w_free;
    logic [NUM_FU-1:0]  w_elig;
    logic               w_gvalid;
    fu_idx_t            w_gidx;
    logic [IDXW-1:0]    w_res_idx;
    fu_idx_t            r_rr_ptr;
    logic [CNTW-1:0]    r_div_cnt;

    // Extra zero bit above the tracker makes a MAX_LAT-cycle slot always read as free.
    assign w_occ_ext = {1'b0, w_occ};

    assign w_free[FU_INT] = ~w_occ_ext[LAT_INT];
    assign w_free[FU_MEM] = ~w_occ_ext[LAT_MEM];
    assign w_free[FU_MUL] = ~w_occ_ext[LAT_MUL];
    assign w_free[FU_DIV] = ~w_occ_ext[LAT_DIV];

    assign w_elig = req & w_free & {(r_div_cnt == '0), 3'b111};

    always_comb begin
        w_gvalid = 1'b0;
        w_gidx   = r_rr_ptr;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            if (!w_gvalid && w_elig[r_rr_ptr + fu_idx_t'(off)]) begin
                w_gvalid = 1'b1;
                w_gidx   = r_rr_ptr + fu_idx_t'(off);
            end
        end
        if (rst) begin
            w_gvalid = 1'b0;
        end
    end

    assign grant = w_gvalid ? fu_onehot(w_gidx) : '0;

    always_comb begin
        w_res_idx = '0;
        case (w_gidx)
            FU_INT:  w_res_idx = IDXW'(LAT_INT - 1);
            FU_MEM:  w_res_idx = IDXW'(LAT_MEM - 1);
            FU_MUL:  w_res_idx = IDXW'(LAT_MUL - 1);
            FU_DIV:  w_res_idx = IDXW'(LAT_DIV - 1);
            default: w_res_idx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_gvalid) begin
            r_rr_ptr <= w_gidx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_gvalid && (w_gidx == FU_DIV)) begin
            r_div_cnt <= CNTW'(LAT_DIV - 1);
        end else if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - 1'b1;
        end
    end

    assign div_busy = (r_div_cnt != '0);

    cdb_slot_tracker #(
        .DEPTH (MAX_LAT),
        .IDXW  (IDXW)
    ) u_slots (
        .clk         (clk),
        .rst         (rst),
        .i_res_vld   (w_gvalid),
        .i_res_idx   (w_res_idx),
        .i_res_own   (w_gidx),
        .o_occ       (w_occ),
        .o_cdb_valid (cdb_valid),
        .o_cdb_src   (cdb_src)
    );

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Bench for cdb_issue_scheduler: absolute-time CDB booking model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_issue_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       cdb_valid;
    logic [1:0] cdb_src;
    logic       div_busy;

    int errors = 0;
    int checks = 0;

    cdb_issue_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src),
        .div_busy  (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int fu);
        case (fu)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    // Model: bookings keyed by absolute cycle number; divider free LAT_DIV cycles after its last issue.
    int  sched[int];
    int  rr_m = 0;
    int  last_div = -100;
    int  tc = 0;
    bit  m_ok = 1'b0;

    always @(negedge clk) begin
        int gi;
        int fu;
        gi = -1;
        if (!rst) begin
            for (int off = 0; off < 4; off++) begin
                fu = (rr_m + off) % 4;
                if (gi < 0 && req[fu] && !sched.exists(tc + lat_of(fu))
                    && (fu != 3 || (tc - last_div) >= 6))
                    gi = fu;
            end
        end
        chk("model_grant", grant, (gi < 0) ? 0 : (1 << gi));
        if (m_ok) begin
            chk("model_cdb_valid", cdb_valid, sched.exists(tc) ? 1 : 0);
            chk("model_cdb_src", cdb_src, sched.exists(tc) ? sched[tc] : 0);
            chk("model_div_busy", div_busy,
                ((tc - last_div) >= 1 && (tc - last_div) <= 5) ? 1 : 0);
        end
        if (rst) begin
            sched.delete();
            rr_m     = 0;
            last_div = -100;
            m_ok     = 1'b1;
        end else if (gi >= 0) begin
            sched[tc + lat_of(gi)] = gi;
            rr_m = (gi + 1) % 4;
            if (gi == 3) last_div = tc;
        end
        tc++;
    end

    task automatic cyc(input logic r, input logic [3:0] q);
        @(posedge clk);
        #1;
        rst = r;
        req = q;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;

        // Reset held two cycles with all requests up
        @(negedge clk);
        chk("rst1_grant", grant, 4'b0000);
        chk("rst1_cdb_valid", cdb_valid, 1'b0);
        cyc(1'b1, 4'b1111);
        chk("rst2_grant", grant, 4'b0000);
        chk("rst2_cdb_valid", cdb_valid, 1'b0);
        chk("rst2_div_busy", div_busy, 1'b0);
        cyc(1'b0, 4'b1111);
        chk("release_grant", grant, 4'b0001);
        cyc(1'b0, 4'b0000);
        chk("release_int_cdb", cdb_valid, 1'b1);
        chk("release_int_src", cdb_src, 2'd0);
        drain(8);

        // Lone INT request; pointer now at 1
        cyc(1'b0, 4'b0001);
        chk("int_grant", grant, 4'b0001);
        cyc(1'b0, 4'b0000);
        chk("int_cdb_valid", cdb_valid, 1'b1);
        chk("int_cdb_src", cdb_src, 2'd0);
        cyc(1'b0, 4'b0000);
        chk("int_cdb_gone", cdb_valid, 1'b0);
        cyc(1'b0, 4'b0011);
        chk("rr_after_int", grant, 4'b0010);
        drain(8);

        // MUL books t0+4, so INT at t0+3 must wait
        cyc(1'b0, 4'b0100);
        chk("mul_grant", grant, 4'b0100);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0001);
        chk("int_blocked", grant, 4'b0000);
        cyc(1'b0, 4'b0001);
        chk("int_late_grant", grant, 4'b0001);
        chk("mul_cdb_valid", cdb_valid, 1'b1);
        chk("mul_cdb_src", cdb_src, 2'd2);
        cyc(1'b0, 4'b0000);
        chk("int_late_cdb", cdb_valid, 1'b1);
        chk("int_late_src", cdb_src, 2'd0);
        drain(8);

        // DIV held: re-issue exactly LAT_DIV cycles later
        cyc(1'b0, 4'b1000);
        chk("div1_grant", grant, 4'b1000);
        chk("div1_busy", div_busy, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 4'b1000);
            chk("div_wait_grant", grant, 4'b0000);
            chk("div_wait_busy", div_busy, 1'b1);
        end
        cyc(1'b0, 4'b1000);
        chk("div2_grant", grant, 4'b1000);
        chk("div2_busy", div_busy, 1'b0);
        chk("div1_cdb_valid", cdb_valid, 1'b1);
        chk("div1_cdb_src", cdb_src, 2'd3);
        for (int i = 7; i <= 11; i++) cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);
        chk("div2_cdb_valid", cdb_valid, 1'b1);
        chk("div2_cdb_src", cdb_src, 2'd3);
        chk("div2_busy_done", div_busy, 1'b0);
        drain(4);

        // INT and MEM held: alternate grants, interleaved results
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 4'b0011);
            chk("alt_grant", grant, (i % 2 == 1) ? 4'b0010 : 4'b0001);
            if (i == 1 || i == 3) begin
                chk("alt_int_cdb", cdb_valid, 1'b1);
                chk("alt_int_src", cdb_src, 2'd0);
            end
            if (i == 2) chk("alt_gap_cdb", cdb_valid, 1'b0);
            if (i == 4) begin
                chk("alt_mem_cdb", cdb_valid, 1'b1);
                chk("alt_mem_src", cdb_src, 2'd1);
            end
        end
        drain(8);

        // Reset discards MUL and DIV bookings and frees the divider
        cyc(1'b0, 4'b1100);
        chk("pre_rst_mul", grant, 4'b0100);
        cyc(1'b0, 4'b1000);
        chk("pre_rst_div", grant, 4'b1000);
        cyc(1'b1, 4'b0001);
        chk("mid_rst_grant", grant, 4'b0000);
        cyc(1'b0, 4'b1000);
        chk("post_rst_busy", div_busy, 1'b0);
        chk("post_rst_div_grant", grant, 4'b1000);
        chk("post_rst_cdb", cdb_valid, 1'b0);
        cyc(1'b0, 4'b0000);
        chk("no_mul_result", cdb_valid, 1'b0);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);
        chk("no_t6_result", cdb_valid, 1'b0);
        cyc(1'b0, 4'b0000);
        chk("no_old_div_result", cdb_valid, 1'b0);
        drain(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
